soc_rst_ctrl: RTL
=================

// Module: soc_rst_ctrl
// PURPOSE
// - Synthesizable reset sequencer and run watchdog at the SoC top, next to the clock source.
// - Synchronizes deassertion of the async board reset and holds all domains in reset for a fixed count.
// - Releases NUM_RST reset domains one at a time; domain 0 (bus fabric) goes first, the core goes last.
// - Runs a cycle watchdog that ends the run on a software done request or on timeout. Supports software-requested warm reset.
// PARAMETERS
// - NUM_RST         4    number of sequenced reset domains (>=1)
// - SYNC_STAGES     2    reset-deassert synchronizer depth (>=2)
// - HOLD_CYCLES     2    cycles all domains stay in reset after the synchronizer releases (>=1)
// - STAGGER_CYCLES  4    cycles between consecutive domain releases (>=1)
// - TIMEOUT_CYCLES  60   RUN-state cycle limit; 0 disables the watchdog
// - CNT_W           32   width of the cycle counter
// PORTS
// - clk           in   1        system clock
// - rstn          in   1        async active-low reset
// - sw_rst_req    in   1        1-cycle warm-reset request
// - done_req      in   1        1-cycle end-of-run request
// - rst_n_o       out  NUM_RST  per-domain active-low resets
// - all_rel_o     out  1        high when every domain is released (RUN)
// - done_o        out  1        sticky: run ended by done_req
// - timeout_o     out  1        sticky: run ended by watchdog
// - cycle_cnt_o   out  CNT_W    cycles spent in RUN
// BEHAVIOUR
// - Reset: one clock; reset is asynchronous and active-low (rstn). rstn low immediately sets
//   rst_n_o='0, all_rel_o=0, done_o=0, timeout_o=0, cycle_cnt_o=0 and state=SYNC.
// - SYNC: a shift register of SYNC_STAGES '1' bits loads on rstn rise. The state moves to HOLD
//   when the last stage goes high.
// - HOLD: a counter runs for HOLD_CYCLES cycles, then the state moves to RELEASE with idx=0.
// - RELEASE: bit idx of rst_n_o rises on entry and every STAGGER_CYCLES after that, for idx=0..NUM_RST-1.
//   Released bits stay high. After the last bit the state moves to RUN on the next cycle.
// - RUN: all_rel_o=1. cycle_cnt_o increments each cycle and saturates at all-ones.
//   - If cycle_cnt_o reaches TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0: timeout_o<=1, state goes to DONE.
//   - done_req=1: done_o<=1, state goes to DONE.
// - DONE: rst_n_o stays all-ones and all_rel_o=0. cycle_cnt_o is frozen. Only rstn leaves DONE.
// - sw_rst_req in HOLD, RELEASE or RUN: the next edge drives rst_n_o='0 synchronously, clears
//   cycle_cnt_o, and enters HOLD (the synchronizer is skipped). sw_rst_req is ignored in SYNC and DONE.
// - Priority in the same cycle: sw_rst_req > done_req > timeout. A timeout with done_req in the same
//   cycle sets done_o=1 and leaves timeout_o=0.
// - done_o and timeout_o are never both 1.
// - Reset sequence latency from rstn rise to rst_n_o[0] high:
//   SYNC_STAGES+HOLD_CYCLES+1 edges.
// - Full release takes (NUM_RST-1)*STAGGER_CYCLES further edges.
// - Glitch-free outputs: every rst_n_o bit comes directly from a flop.
// STRUCTURE
// - Package soc_rst_pkg:
//   - state_e {SYNC,HOLD,RELEASE,RUN,DONE}
//   - default parameter constants
//   - localparam helper for the idx width, $clog2(NUM_RST) with a minimum of 1
// - Sub-module rst_sync: SYNC_STAGES-deep async-assert/sync-deassert synchronizer,
//   instantiated once.
// - Top: FSM, hold/stagger counter (width from max(HOLD_CYCLES,STAGGER_CYCLES)),
//   domain index, cycle counter, sticky flags.
// TESTING (clk period 10ns, defaults)
// - Power-on: rstn low 20ns then high -> rst_n_o bits rise 0001,0011,0111,1111 at edges 5,9,13,17
//   after rstn rises; all_rel_o=1 from edge 18.
// - Watchdog: no done_req -> timeout_o=1 and done_o=0 after 60 RUN cycles; cycle_cnt_o=59 and frozen;
//   all_rel_o=0.
// - Done: pulse done_req at RUN cycle 10 -> done_o=1, cycle_cnt_o=10, timeout_o stays 0 forever.
// - Warm reset: pulse sw_rst_req at RUN cycle 5 -> next edge rst_n_o=0000, cycle_cnt_o=0, then
//   HOLD(2) and stagger again with no SYNC delay.
// - Collisions: done_req with timeout in the same cycle -> done_o only.
//   sw_rst_req with done_req in the same cycle -> warm reset, done_o=0.
// - Mid-sequence rstn: drop rstn during RELEASE at idx=2 -> rst_n_o=0000 immediately (asynchronous);
//   the full power-on sequence then repeats.
// - Parameter sweep: NUM_RST=1, TIMEOUT_CYCLES=0, SYNC_STAGES=3 -> single release at edge 6 after rstn rises;
//   the run never times out.

Source files
------------

// File: rtl/soc_rst_pkg.sv
// Shared types and constants for the SoC reset sequencer and run watchdog.
package soc_rst_pkg;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int DEF_NUM_RST        = 4;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_HOLD_CYCLES    = 2;
  localparam int DEF_STAGGER_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES = 60;
  localparam int DEF_CNT_W          = 32;

  // A 1-bit field is still needed when only one value is possible.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/soc_rst_ctrl_if.sv
// Request/status bundle between the reset sequencer and the rest of the SoC.
interface soc_rst_ctrl_if
  import soc_rst_pkg::*;
#(
  parameter int NUM_RST = DEF_NUM_RST,
  parameter int CNT_W   = DEF_CNT_W
);
  // Handshake: sw_rst_req and done_req are single-cycle pulses with no ready;
  // each is acted on at the rising clk edge that samples it high.
  logic               sw_rst_req;
  logic               done_req;
  logic [NUM_RST-1:0] rst_n_o;
  logic               all_rel_o;
  logic               done_o;
  logic               timeout_o;
  logic [CNT_W-1:0]   cycle_cnt_o;
  state_e             state_o;

  modport master (
    output sw_rst_req, done_req,
    input  rst_n_o, all_rel_o, done_o, timeout_o, cycle_cnt_o, state_o
  );

  modport slave (
    input  sw_rst_req, done_req,
    output rst_n_o, all_rel_o, done_o, timeout_o, cycle_cnt_o, state_o
  );
endinterface

// File: rtl/soc_rst_ctrl_sync.sv
// Async-assert / sync-deassert reset synchronizer for the board reset.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  output logic rst_n_sync_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], 1'b1};
  end

  assign rst_n_sync_o = sync_q[STAGES-1];
endmodule

// File: rtl/soc_rst_ctrl.sv
// Reset sequencer: synchronizes board reset, holds, staggers domain releases,
// then runs a cycle watchdog until done_req, timeout or warm reset.
module soc_rst_ctrl
  import soc_rst_pkg::*;
#(
  parameter int NUM_RST        = DEF_NUM_RST,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rstn,
  soc_rst_ctrl_if.slave  bus
);
  localparam int TMR_W = clog2_min1(max2(HOLD_CYCLES, STAGGER_CYCLES));
  localparam int IDX_W = clog2_min1(NUM_RST);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] STAG_LAST = TMR_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RST - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_RST-1:0] rst_n_q, rst_n_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               done_q, done_d;
  logic               tmo_q, tmo_d;
  logic               sync_rel;

  rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .rstn         (rstn),
    .rst_n_sync_o (sync_rel)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SYNC;
      tmr_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    case (state_q)
      SYNC: begin
        if (sync_rel) begin
          state_d = HOLD;
          tmr_d   = '0;
        end
      end
      HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d    = RELEASE;
          tmr_d      = '0;
          idx_d      = '0;
          rst_n_d    = '0;
          rst_n_d[0] = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RELEASE: begin
        // Released bits are a contiguous run from bit 0, so shifting in a 1 frees the next domain.
        if (idx_q == IDX_LAST) begin
          state_d = RUN;
        end else if (tmr_q == STAG_LAST) begin
          tmr_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
          rst_n_d = NUM_RST'({rst_n_q, 1'b1});
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RUN: begin
        if (bus.done_req) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cyc_q == TMO_LAST)) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else if (cyc_q != '1) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      DONE:    state_d = DONE;
      default: state_d = SYNC;
    endcase

    // Warm reset overrides any other event this cycle and skips the synchronizer.
    if (bus.sw_rst_req && (state_q inside {HOLD, RELEASE, RUN})) begin
      state_d = HOLD;
      tmr_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      cyc_d   = '0;
      done_d  = done_q;
      tmo_d   = tmo_q;
    end
  end

  assign bus.rst_n_o     = rst_n_q;
  assign bus.all_rel_o   = (state_q == RUN);
  assign bus.done_o      = done_q;
  assign bus.timeout_o   = tmo_q;
  assign bus.cycle_cnt_o = cyc_q;
  assign bus.state_o     = state_q;
endmodule
